// File: rtl/reg_read_stage.sv
// reg_read_stage: decode/operand-read stage.
// Holds the 32x32 register file (write port driven by write-back), reads rs/rt
// with same-cycle write-through bypass, detects load-use hazards and registers
// operands into the ID/EX pipeline register.
// Optional: define STALL_COUNT_EN to add a saturating StallCount output.
module reg_read_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [31:0]           Instruction,
    input  logic                  InstValid,
    input  logic                  Flush,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] rDestSelected,
    input  logic [DATA_WIDTH-1:0] regWriteData,
    input  logic                  EX_MemRead,
    input  logic [ADDR_WIDTH-1:0] EX_rDest,
    output logic                  Stall,
    output logic                  OutValid,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic [ADDR_WIDTH-1:0] OutRs,
    output logic [ADDR_WIDTH-1:0] OutRt,
`ifdef STALL_COUNT_EN
    output logic [DATA_WIDTH-1:0] OutImm,
    output logic [31:0]           StallCount
`else
    output logic [DATA_WIDTH-1:0] OutImm
`endif
);

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpSw    = 6'h2B;

    logic [DATA_WIDTH-1:0] regFile [REG_COUNT];

    logic [5:0]            opcode;
    logic [ADDR_WIDTH-1:0] rs;
    logic [ADDR_WIDTH-1:0] rt;
    logic [DATA_WIDTH-1:0] imm;
    logic                  usesRt;
    logic                  wbActive;
    logic [DATA_WIDTH-1:0] rsData;
    logic [DATA_WIDTH-1:0] rtData;

    assign opcode   = Instruction[31:26];
    assign rs       = ADDR_WIDTH'(Instruction[25:21]);
    assign rt       = ADDR_WIDTH'(Instruction[20:16]);
    assign imm      = {{(DATA_WIDTH-16){Instruction[15]}}, Instruction[15:0]};
    assign wbActive = RegWrite && (rDestSelected != '0);

    // Decode which instructions actually consume the rt operand.
    always_comb begin
        usesRt = 1'b0;
        case (opcode)
            OpRType, OpBeq, OpBne, OpSw: usesRt = 1'b1;
            default:                     usesRt = 1'b0;
        endcase
    end

    // Operand read: register 0 is zero, otherwise a same-cycle write-back wins.
    always_comb begin
        rsData = '0;
        rtData = '0;
        if (rs != '0) begin
            rsData = (wbActive && rDestSelected == rs) ? regWriteData : regFile[rs];
        end
        if (rt != '0) begin
            rtData = (wbActive && rDestSelected == rt) ? regWriteData : regFile[rt];
        end
    end

    // Load-use hazard: the load in EX produces a register this instruction needs.
    always_comb begin
        Stall = InstValid && EX_MemRead && (EX_rDest != '0) &&
                ((EX_rDest == rs) || (usesRt && (EX_rDest == rt)));
    end

    // Register file: cleared by reset; register 0 is never written.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regFile[i] <= '0;
            end
        end else if (wbActive) begin
            regFile[rDestSelected] <= regWriteData;
        end
    end

    // ID/EX pipeline register: reset, then flush, then stall bubble, then load.
    always_ff @(posedge Clock) begin
        if (Reset || Flush || Stall) begin
            OutValid  <= 1'b0;
            ReadData1 <= '0;
            ReadData2 <= '0;
            OutRs     <= '0;
            OutRt     <= '0;
            OutImm    <= '0;
        end else begin
            OutValid  <= InstValid;
            ReadData1 <= rsData;
            ReadData2 <= rtData;
            OutRs     <= rs;
            OutRt     <= rt;
            OutImm    <= imm;
        end
    end

`ifdef STALL_COUNT_EN
    // Count stalled cycles, saturating at all-ones.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            StallCount <= '0;
        end else if (Stall && (StallCount != '1)) begin
            StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_read_stage.sv
// Scoreboard bench for reg_read_stage: the driver pushes the expected ID/EX
// contents for every cycle, a monitor pops and compares after each edge.
module tb_reg_read_stage;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] Instruction;
    logic        InstValid;
    logic        Flush;
    logic        RegWrite;
    logic [4:0]  rDestSelected;
    logic [31:0] regWriteData;
    logic        EX_MemRead;
    logic [4:0]  EX_rDest;
    logic        Stall;
    logic        OutValid;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [4:0]  OutRs;
    logic [4:0]  OutRt;
    logic [31:0] OutImm;
`ifdef STALL_COUNT_EN
    logic [31:0] StallCount;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
    } out_t;

    out_t expQ[$];

    reg_read_stage dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Instruction  (Instruction),
        .InstValid    (InstValid),
        .Flush        (Flush),
        .RegWrite     (RegWrite),
        .rDestSelected(rDestSelected),
        .regWriteData (regWriteData),
        .EX_MemRead   (EX_MemRead),
        .EX_rDest     (EX_rDest),
        .Stall        (Stall),
        .OutValid     (OutValid),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .OutRs        (OutRs),
        .OutRt        (OutRt),
`ifdef STALL_COUNT_EN
        .OutImm       (OutImm),
        .StallCount   (StallCount)
`else
        .OutImm       (OutImm)
`endif
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] mkInst(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic out_t mkOut(input logic v, input logic [31:0] d1, input logic [31:0] d2,
                                   input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [31:0] im);
        out_t o;
        o.valid = v;
        o.rd1   = d1;
        o.rd2   = d2;
        o.rs    = rs;
        o.rt    = rt;
        o.imm   = im;
        return o;
    endfunction

    // Drive one cycle of inputs, check Stall, queue the expected ID/EX contents.
    task automatic step(input string name, input logic rst, input logic [31:0] inst,
                        input logic iv, input logic fl, input logic rw, input logic [4:0] rd,
                        input logic [31:0] wd, input logic exmr, input logic [4:0] exrd,
                        input logic expStall, input out_t expOut);
        @(negedge Clock);
        Reset         = rst;
        Instruction   = inst;
        InstValid     = iv;
        Flush         = fl;
        RegWrite      = rw;
        rDestSelected = rd;
        regWriteData  = wd;
        EX_MemRead    = exmr;
        EX_rDest      = exrd;
        #1;
        checks++;
        if (Stall !== expStall) begin
            failures++;
            $display("FAIL stall[%s]: got %b want %b", name, Stall, expStall);
        end
        expQ.push_back(expOut);
    endtask

    // Monitor: after each rising edge compare ID/EX against the next queued entry.
    initial begin
        out_t e;
        out_t a;
        forever begin
            @(posedge Clock);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                a = mkOut(OutValid, ReadData1, ReadData2, OutRs, OutRt, OutImm);
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL idex: got v=%b d1=%h d2=%h rs=%0d rt=%0d imm=%h want v=%b d1=%h d2=%h rs=%0d rt=%0d imm=%h",
                             a.valid, a.rd1, a.rd2, a.rs, a.rt, a.imm,
                             e.valid, e.rd1, e.rd2, e.rs, e.rt, e.imm);
                end
            end
        end
    end

    initial begin
        out_t z;
        int   budget;
        z = mkOut(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0);

        // Reset for two cycles with a valid-looking instruction present.
        step("rst0", 1, mkInst(6'h00, 5'd5, 5'd6, 16'h0020), 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0, z);
        step("rst1", 1, mkInst(6'h00, 5'd5, 5'd6, 16'h0020), 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0, z);
        // First valid instruction after reset.
        step("read56", 0, mkInst(6'h00, 5'd5, 5'd6, 16'h0020), 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0,
             mkOut(1, 32'h0, 32'h0, 5'd5, 5'd6, 32'h0000_0020));
        // Write reg8 with no instruction in decode.
        step("wr8", 0, 32'h0, 0, 0, 1, 5'd8, 32'hDEAD_BEEF, 0, 5'd0, 0, z);
        step("read8", 0, mkInst(6'h00, 5'd8, 5'd0, 16'h0020), 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0,
             mkOut(1, 32'hDEAD_BEEF, 32'h0, 5'd8, 5'd0, 32'h0000_0020));
        // Same-cycle bypass on rs=9, rt=8 from the file, negative immediate.
        step("bypass9", 0, mkInst(6'h00, 5'd9, 5'd8, 16'h8001), 1, 0, 1, 5'd9, 32'h1234_5678,
             0, 5'd0, 0, mkOut(1, 32'h1234_5678, 32'hDEAD_BEEF, 5'd9, 5'd8, 32'hFFFF_8001));
        // Write to reg0 ignored even for bypass; rt=9 now from the file.
        step("wr0", 0, mkInst(6'h08, 5'd0, 5'd9, 16'h7FFF), 1, 0, 1, 5'd0, 32'hFFFF_FFFF,
             0, 5'd0, 0, mkOut(1, 32'h0, 32'h1234_5678, 5'd0, 5'd9, 32'h0000_7FFF));
        step("read0", 0, mkInst(6'h00, 5'd0, 5'd0, 16'h0000), 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0,
             mkOut(1, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0));
        // Load-use on rt of an R-type; a write-back to reg10 still commits.
        step("lduse_r", 0, mkInst(6'h00, 5'd1, 5'd10, 16'h0020), 1, 0, 1, 5'd10, 32'hA5A5_A5A5,
             1, 5'd10, 1, z);
        // addi does not use rt: no stall, rt operand still read.
        step("lduse_addi", 0, mkInst(6'h08, 5'd1, 5'd10, 16'h0004), 1, 0, 0, 5'd0, 32'h0,
             1, 5'd10, 0, mkOut(1, 32'h0, 32'hA5A5_A5A5, 5'd1, 5'd10, 32'h0000_0004));
        // Load into register 0 never stalls.
        step("lduse_r0", 0, mkInst(6'h00, 5'd0, 5'd0, 16'h0000), 1, 0, 0, 5'd0, 32'h0,
             1, 5'd0, 0, mkOut(1, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0));
        // Flush together with stall: bubble, Stall still high.
        step("flush_stall", 0, mkInst(6'h00, 5'd10, 5'd8, 16'h0020), 1, 1, 0, 5'd0, 32'h0,
             1, 5'd10, 1, z);
        // Flush alone.
        step("flush", 0, mkInst(6'h00, 5'd10, 5'd8, 16'h0020), 1, 1, 0, 5'd0, 32'h0,
             0, 5'd0, 0, z);
        // sw uses rt: third stall.
        step("lduse_sw", 0, mkInst(6'h2B, 5'd2, 5'd10, 16'h0010), 1, 0, 0, 5'd0, 32'h0,
             1, 5'd10, 1, z);
`ifdef STALL_COUNT_EN
        @(posedge Clock);
        #1;
        checks++;
        if (StallCount !== 32'd3) begin
            failures++;
            $display("FAIL stallcount: got %0d want 3", StallCount);
        end
`endif
        // Invalid instruction with matching load does not stall.
        step("inv_nostall", 0, mkInst(6'h00, 5'd10, 5'd10, 16'h0000), 0, 0, 0, 5'd0, 32'h0,
             1, 5'd10, 0, mkOut(0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd10, 5'd10, 32'h0));
        // Reset mid-operation clears the register file.
        step("rst_mid", 1, mkInst(6'h00, 5'd8, 5'd9, 16'h0020), 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0,
             z);
        step("read_after_rst", 0, mkInst(6'h00, 5'd8, 5'd9, 16'h0020), 1, 0, 0, 5'd0, 32'h0,
             0, 5'd0, 0, mkOut(1, 32'h0, 32'h0, 5'd8, 5'd9, 32'h0000_0020));
        step("idle", 0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0, z);

        budget = 10;
        while (expQ.size() > 0 && budget > 0) begin
            @(posedge Clock);
            budget--;
        end
        #5;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
